div_cfg_arbiter: RTL and testbench

- Shares the clock-divider configuration registers between three command sources: register bus (port 0), UART command parser (port 1) and SPI command parser (port 2).
- Arbitrates their accesses round-robin and owns the enable and ratio registers.
- Schedules ratio changes so the divider only picks up a new ratio at a divided-period boundary, which keeps div_clk glitch-free.
- Sits between the per-interface command decoders and the divider core inside the divider top level.

---
 rtl/div_cfg_arbiter.sv | 160 ++++++++++++++++
 tb/tb_div_cfg_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/div_cfg_arbiter.sv
// Round-robin arbiter sharing the clock-divider CTRL/RATIO/STATUS registers
// between three command sources, with boundary-aligned ratio commits.
module div_cfg_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int RATIO_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic [2:0]              req_i,
  input  logic [2:0]              req_wr_i,
  input  logic [3*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [3*DATA_WIDTH-1:0] req_wdata_i,
  output logic [2:0]              ack_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  input  logic                    div_period_end_i,
  output logic                    div_en_o,
  output logic [RATIO_WIDTH-1:0]  div_ratio_o,
  output logic                    cfg_pending_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;

  localparam logic [ADDR_WIDTH-1:0]  ADDR_CTRL   = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_RATIO  = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_STATUS = ADDR_WIDTH'(8'h08);
  localparam logic [RATIO_WIDTH-1:0] RATIO_MIN   = RATIO_WIDTH'(2);

  function automatic logic [1:0] next_port(input logic [1:0] p);
    case (p)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [RATIO_WIDTH-1:0] clamp_ratio(input logic [RATIO_WIDTH-1:0] v);
    if (v < RATIO_MIN) return RATIO_MIN;
    else               return v;
  endfunction

  state_t                  state_r, state_s;
  logic [1:0]              ptr_r, win_r, last_r;
  logic                    wr_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic                    en_r, pending_r;
  logic [RATIO_WIDTH-1:0]  staged_r, ratio_r;
  logic [2:0]              ack_r;
  logic [DATA_WIDTH-1:0]   rdata_r;

  logic                    grant_any_s;
  logic [1:0]              grant_idx_s, cand_s;
  logic [DATA_WIDTH-1:0]   rd_s;
  logic                    ctrl_wr_s, ratio_wr_s, commit_s;
  logic                    unused_wdata_s;

  assign unused_wdata_s = ^wdata_r[DATA_WIDTH-1:RATIO_WIDTH];

  // Round-robin winner search starting at the pointer
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = ptr_r;
    cand_s      = ptr_r;
    for (int k = 0; k < 3; k++) begin
      if (!grant_any_s && req_i[cand_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_any_s = grant_any_s;
      end
      cand_s = next_port(cand_s);
    end
  end

  // Register decode, read mux and commit condition
  always_comb begin
    ctrl_wr_s  = (state_r == ACCESS) && wr_r && (addr_r == ADDR_CTRL);
    ratio_wr_s = (state_r == ACCESS) && wr_r && (addr_r == ADDR_RATIO);
    // Disabled divider has no boundary to wait for, so commit at once
    commit_s   = pending_r && (div_period_end_i || !en_r);
    rd_s       = '0;
    case (addr_r)
      ADDR_CTRL:   rd_s[0] = en_r;
      ADDR_RATIO:  rd_s[RATIO_WIDTH-1:0] = staged_r;
      ADDR_STATUS: begin
        rd_s[0]                = pending_r;
        rd_s[9:8]              = last_r;
        rd_s[16 +: RATIO_WIDTH] = ratio_r;
      end
      default:     rd_s = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (grant_any_s) state_s = ACCESS; else state_s = IDLE;
      ACCESS:  state_s = ACK;
      ACK:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Transaction latch, register file and ack/rdata outputs
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r     <= 2'd0;
      win_r     <= 2'd0;
      last_r    <= 2'd0;
      wr_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      en_r      <= 1'b0;
      pending_r <= 1'b0;
      staged_r  <= RATIO_MIN;
      ratio_r   <= RATIO_MIN;
      ack_r     <= 3'b000;
      rdata_r   <= '0;
    end else begin
      ack_r   <= 3'b000;
      rdata_r <= '0;
      if (state_r == IDLE && grant_any_s) begin
        win_r   <= grant_idx_s;
        last_r  <= grant_idx_s;
        wr_r    <= req_wr_i[grant_idx_s];
        addr_r  <= req_addr_i[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_r <= req_wdata_i[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state_r == ACCESS) begin
        ack_r   <= 3'b001 << win_r;
        rdata_r <= wr_r ? '0 : rd_s;
      end
      if (state_r == ACK) ptr_r <= next_port(win_r);
      if (ctrl_wr_s) en_r <= wdata_r[0];
      // Commit uses the old staged value even when a write lands in the same cycle
      if (commit_s) ratio_r <= staged_r;
      if (ratio_wr_s) begin
        staged_r  <= clamp_ratio(wdata_r[RATIO_WIDTH-1:0]);
        pending_r <= 1'b1;
      end else if (commit_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  assign ack_o         = ack_r;
  assign rdata_o       = rdata_r;
  assign div_en_o      = en_r;
  assign div_ratio_o   = ratio_r;
  assign cfg_pending_o = pending_r;

endmodule

// File: tb/tb_div_cfg_arbiter.sv
// Directed self-checking bench for div_cfg_arbiter.
module tb_div_cfg_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  req_wr = 3'b000;
  logic [23:0] req_addr = 24'h0;
  logic [95:0] req_wdata = 96'h0;
  logic [2:0]  ack;
  logic [31:0] rdata;
  logic        pe = 1'b0;
  logic        en;
  logic [15:0] ratio;
  logic        pending;

  int total = 0;
  int bad = 0;
  logic        pend_ack, en_ack;
  logic [15:0] ratio_ack;
  logic [31:0] rd;

  div_cfg_arbiter dut (
    .clk_i(clk), .rst_n(rst_n), .req_i(req), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .ack_o(ack), .rdata_o(rdata),
    .div_period_end_i(pe), .div_en_o(en), .div_ratio_o(ratio), .cfg_pending_o(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int p, input logic wr, input logic [7:0] addr,
                     input logic [31:0] wd, output logic [31:0] rdo);
    int lat;
    lat = 0;
    req[p] = 1'b1;
    req_wr[p] = wr;
    req_addr[p*8 +: 8] = addr;
    req_wdata[p*32 +: 32] = wd;
    do begin
      tick();
      lat++;
    end while (ack[p] !== 1'b1 && lat < 10);
    chk("ack_latency", lat, 2);
    chk("ack_onehot", {29'd0, ack}, 32'd1 << p);
    rdo = rdata;
    pend_ack = pending;
    en_ack = en;
    ratio_ack = ratio;
    req[p] = 1'b0;
    tick();
    chk("ack_single", {29'd0, ack}, 32'd0);
  endtask

  task automatic pulse();
    pe = 1'b1;
    tick();
    pe = 1'b0;
  endtask

  // RATIO write whose ACCESS cycle coincides with a period-end pulse
  task automatic wr_on_pulse(input int p, input logic [31:0] val);
    req[p] = 1'b1;
    req_wr[p] = 1'b1;
    req_addr[p*8 +: 8] = 8'h04;
    req_wdata[p*32 +: 32] = val;
    tick();
    pe = 1'b1;
    tick();
    pe = 1'b0;
    chk("pulse_wr_ack", {29'd0, ack}, 32'd1 << p);
    req[p] = 1'b0;
    tick();
  endtask

  initial begin
    int cnt;
    repeat (3) tick();
    chk("rst_en", {31'd0, en}, 32'd0);
    chk("rst_ratio", {16'd0, ratio}, 32'd2);
    chk("rst_pending", {31'd0, pending}, 32'd0);
    chk("rst_ack", {29'd0, ack}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    txn(0, 1'b0, 8'h04, 32'h0, rd);
    chk("rd_ratio_rst", rd, 32'd2);
    txn(0, 1'b0, 8'h00, 32'h0, rd);
    chk("rd_ctrl_rst", rd, 32'd0);
    chk("ratio_rst2", {16'd0, ratio}, 32'd2);

    // disabled: commit right after pending appears
    txn(1, 1'b1, 8'h04, 32'd10, rd);
    chk("wr10_pend_ack", {31'd0, pend_ack}, 32'd1);
    chk("wr10_pend_after", {31'd0, pending}, 32'd0);
    chk("wr10_ratio", {16'd0, ratio}, 32'd10);
    chk("wr10_rdata", rd, 32'd0);
    txn(1, 1'b1, 8'h00, 32'd1, rd);
    chk("en_on_ack", {31'd0, en_ack}, 32'd1);

    // enabled: wait for boundary
    txn(2, 1'b1, 8'h04, 32'd6, rd);
    repeat (2) tick();
    chk("wr6_hold_ratio", {16'd0, ratio}, 32'd10);
    chk("wr6_hold_pend", {31'd0, pending}, 32'd1);
    pulse();
    chk("wr6_commit_ratio", {16'd0, ratio}, 32'd6);
    chk("wr6_commit_pend", {31'd0, pending}, 32'd0);

    wr_on_pulse(2, 32'd20);
    chk("same_cyc_ratio", {16'd0, ratio}, 32'd6);
    chk("same_cyc_pend", {31'd0, pending}, 32'd1);
    pulse();
    chk("same_cyc_commit", {16'd0, ratio}, 32'd20);

    txn(2, 1'b1, 8'h04, 32'd8, rd);
    chk("wr8_pend", {31'd0, pending}, 32'd1);
    wr_on_pulse(2, 32'd12);
    chk("old_staged_commit", {16'd0, ratio}, 32'd8);
    chk("new_still_pend", {31'd0, pending}, 32'd1);
    pulse();
    chk("wr12_commit", {16'd0, ratio}, 32'd12);
    chk("wr12_pend", {31'd0, pending}, 32'd0);

    // fairness with all three requesting
    req_wr = 3'b000;
    req_addr = 24'h0;
    req = 3'b111;
    for (int g = 0; g < 9; g++) begin
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (ack === 3'b000 && cnt < 10);
      chk("rr_order", {29'd0, ack}, 32'd1 << (g % 3));
      chk("rr_spacing", cnt, (g == 0) ? 32'd2 : 32'd3);
    end
    req = 3'b000;
    tick();

    // disable takes effect immediately, clamp checks
    txn(0, 1'b1, 8'h00, 32'd0, rd);
    chk("dis_on_ack", {31'd0, en_ack}, 32'd0);
    txn(0, 1'b1, 8'h04, 32'd0, rd);
    txn(0, 1'b0, 8'h04, 32'd0, rd);
    chk("clamp0_rd", rd, 32'd2);
    chk("clamp0_ratio", {16'd0, ratio}, 32'd2);
    txn(0, 1'b1, 8'h04, 32'd7, rd);
    chk("ratio7", {16'd0, ratio}, 32'd7);
    txn(0, 1'b1, 8'h04, 32'd1, rd);
    txn(0, 1'b0, 8'h04, 32'd0, rd);
    chk("clamp1_rd", rd, 32'd2);
    chk("clamp1_ratio", {16'd0, ratio}, 32'd2);
    txn(1, 1'b0, 8'h3C, 32'd0, rd);
    chk("unmapped_rd", rd, 32'd0);
    txn(1, 1'b0, 8'h08, 32'd0, rd);
    chk("status_rd", rd, 32'h0002_0100);
    txn(1, 1'b1, 8'h08, 32'hFFFF_FFFF, rd);
    txn(1, 1'b0, 8'h08, 32'd0, rd);
    chk("status_ro", rd, 32'h0002_0100);
    chk("status_wr_en", {31'd0, en}, 32'd0);

    // reset during ACCESS of a RATIO write
    txn(0, 1'b1, 8'h00, 32'd1, rd);
    chk("en_again", {31'd0, en}, 32'd1);
    req[0] = 1'b1;
    req_wr[0] = 1'b1;
    req_addr[7:0] = 8'h04;
    req_wdata[31:0] = 32'd50;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", {31'd0, en}, 32'd0);
    req[0] = 1'b0;
    tick();
    chk("mid_rst_ack", {29'd0, ack}, 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ack !== 3'b000) cnt++;
    end
    chk("post_rst_no_ack", cnt, 32'd0);
    chk("post_rst_ratio", {16'd0, ratio}, 32'd2);
    chk("post_rst_en", {31'd0, en}, 32'd0);
    chk("post_rst_pend", {31'd0, pending}, 32'd0);
    txn(0, 1'b0, 8'h04, 32'd0, rd);
    chk("post_rst_staged", rd, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
